mbist_sequencer: RTL and testbench
==================================

# mbist_sequencer

Test-list sequencer for the MBIST controller. It drives the 4-bit `select` code into the control decoder and issues `rst_done` between tests to clear the decoder's latched control lines. It walks an enabled subset of test codes 1..6: background (1), blanket (2), checkerboard (3), reverse checkerboard (4), March C (5) and March A (6). For each test it waits for the algorithm engine's completion, watches the comparator, and applies a watchdog. At the end it reports a pass/fail summary to the top level.

## Interface
- `TEST_MASK`, 6'b111111: bit k-1 enables test code k.
- `TIMEOUT`, 1024: maximum RUN cycles per test before a watchdog failure (≥2).
- `CLR_CYC`, 1: cycles `rst_done` is held between tests (≥1).
- `STOP_ON_FAIL`, 0: 1 means end the sequence after the first failing test.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled in IDLE or FINISH only.
- `test_done`  in  1  engine reports the current algorithm has finished.
- `fail_in`  in  1  comparator mismatch, valid per cycle.
- `select`  out  4  test code to the control decoder; 0 means none.
- `rst_done`  out  1  clear pulse to the control decoder.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence complete; held until next `start` or reset.
- `pass`  out  1  valid when `done`=1; 1 if no test failed.
- `fail_map`  out  6  sticky per-test failure bits; bit k-1 is code k.
- `fail_code`  out  4  code of the first failing test; 0 if none.
- `timeout`  out  1  sticky; at least one test hit the watchdog.

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE.
- FSM states: IDLE, ISSUE, RUN, CLEAR, FINISH.
- IDLE or FINISH with `start`=1:
  - clear `fail_map`, `fail_code`, `timeout`, `pass` and `done`;
  - load the lowest enabled code into `select`, set `busy`=1, go to ISSUE.
  - If `TEST_MASK`=0, go straight to FINISH with `pass`=1 and `done`=1.
- ISSUE: one cycle; `test_done` and `fail_in` are ignored because the decoder registers `select`. Then go to RUN with the watchdog counter at 0.
- RUN:
  - `fail_in`=1 sets `fail_map[code-1]`. It also sets `fail_code`=code if `fail_code` was 0.
  - `test_done`=1 goes to CLEAR. If `fail_in` is 1 in the same cycle, it is still recorded.
  - If the counter reaches `TIMEOUT-1` without `test_done`: set `timeout`, set `fail_map[code-1]`, set `fail_code` if still 0, go to CLEAR.
  - The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- CLEAR: `select`=0 and `rst_done`=1 for `CLR_CYC` cycles. Then take one of these paths:
  - If `STOP_ON_FAIL`=1 and the test just finished failed, go to FINISH.
  - Otherwise, if there is a higher enabled code, load it and go to ISSUE.
  - Otherwise go to FINISH.
- FINISH: `select`=0, `rst_done`=0, `busy`=0, `done`=1, `pass`=(`fail_map`==0).
- `start` while `busy`=1 is ignored. Inputs outside RUN are ignored.
- `select` is stable from ISSUE through RUN. It never changes directly from one nonzero code to another; a CLEAR always sits between tests.

## Timing
- Edge E0 samples `start`. After E0: ISSUE, `select`=first code, `busy`=1.
- After E1: RUN. The first `test_done` that counts is the one sampled at E2.
- `test_done` sampled at edge En: after En, `select`=0 and `rst_done`=1.
  - After En+CLR_CYC: either ISSUE with the next code, or FINISH with `done`=1.
- Per-test overhead outside RUN is 1+`CLR_CYC` cycles.
- A watchdog hit raises `timeout` on the same edge the FSM enters CLEAR, which is `TIMEOUT` cycles after entering RUN.
- Asserting `rst` at any point, including mid-RUN or mid-CLEAR, forces all outputs to 0 immediately. No `rst_done` pulse is issued, and the decoder relies on `select`=0.

## Test plan
- Defaults; `test_done` 10 cycles into each RUN, `fail_in`=0 → `select` sequence 1,2,3,4,5,6, six `rst_done` pulses of 1 cycle, then `done`=1, `pass`=1, `fail_map`=0.
- `fail_in` pulsed during code 3 and code 5 → `fail_map`=6'b010100, `fail_code`=3, `pass`=0, all six tests run. With `STOP_ON_FAIL`=1 → the sequence ends after code 3 and `select` never shows 4.
- `TEST_MASK`=6'b010010 → only codes 2 and 5 appear. `TEST_MASK`=0 → `done`=1 and `pass`=1 one cycle after `start`, `select` stays 0.
- `TIMEOUT`=16, no `test_done` on code 1 → after 16 RUN cycles: `timeout`=1, `fail_map[0]`=1, `fail_code`=1, and the sequence continues to code 2.
- `start` pulsed during RUN → no effect. `test_done` during ISSUE → ignored. `test_done` and `fail_in` in the same cycle → failure recorded.
- `rst` asserted mid-RUN of code 4 → all outputs are 0 before the next edge. A new `start` restarts from code 1 with cleared results.

Source files
------------

// File: rtl/mbist_sequencer.sv
// MBIST test-list sequencer: walks the enabled test codes, pulses a decoder clear
// between tests, applies a per-test watchdog and reports a pass/fail summary.
module mbist_sequencer #(
    parameter logic [5:0] TEST_MASK    = 6'b111111,
    parameter int         TIMEOUT      = 1024,
    parameter int         CLR_CYC      = 1,
    parameter bit         STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       test_done,
    input  logic       fail_in,
    output logic [3:0] select,
    output logic       rst_done,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_map,
    output logic [3:0] fail_code,
    output logic       timeout
);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int CLR_W = $clog2(CLR_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_RUN    = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Lowest enabled code strictly above cur; zero when none remains.
    function automatic logic [3:0] next_code(input logic [3:0] cur);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 6; k >= 1; k--) begin
            if (TEST_MASK[k-1] && (4'(k) > cur)) begin
                res = 4'(k);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [5:0] code_bit(input logic [3:0] code);
        logic [5:0] res;
        case (code)
            4'd1:    res = 6'b000001;
            4'd2:    res = 6'b000010;
            4'd3:    res = 6'b000100;
            4'd4:    res = 6'b001000;
            4'd5:    res = 6'b010000;
            4'd6:    res = 6'b100000;
            default: res = 6'b000000;
        endcase
        return res;
    endfunction

    state_t             state_r, state_s;
    logic [3:0]         select_r, select_s;
    logic [3:0]         code_r, code_s;
    logic               rst_done_r, rst_done_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               pass_r, pass_s;
    logic [5:0]         fail_map_r, fail_map_s;
    logic [3:0]         fail_code_r, fail_code_s;
    logic               timeout_r, timeout_s;
    logic [WD_W-1:0]    wd_r, wd_s;
    logic [CLR_W-1:0]   clr_r, clr_s;
    logic [3:0]         first_s;
    logic [3:0]         nxt_s;
    logic [5:0]         cur_bit_s;
    logic               hit_s;
    logic               wd_exp_s;

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_s     = state_r;
        select_s    = select_r;
        code_s      = code_r;
        rst_done_s  = rst_done_r;
        busy_s      = busy_r;
        done_s      = done_r;
        pass_s      = pass_r;
        fail_map_s  = fail_map_r;
        fail_code_s = fail_code_r;
        timeout_s   = timeout_r;
        wd_s        = wd_r;
        clr_s       = clr_r;
        first_s     = next_code(4'd0);
        nxt_s       = next_code(code_r);
        cur_bit_s   = code_bit(code_r);
        hit_s       = 1'b0;
        wd_exp_s    = (wd_r == WD_LAST);
        case (state_r)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    fail_map_s  = 6'd0;
                    fail_code_s = 4'd0;
                    timeout_s   = 1'b0;
                    pass_s      = 1'b0;
                    done_s      = 1'b0;
                    if (first_s == 4'd0) begin
                        state_s = ST_FINISH;
                        pass_s  = 1'b1;
                        done_s  = 1'b1;
                    end else begin
                        state_s  = ST_ISSUE;
                        select_s = first_s;
                        code_s   = first_s;
                        busy_s   = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            // The decoder registers select here, so engine inputs are not trusted yet.
            ST_ISSUE: begin
                state_s = ST_RUN;
                wd_s    = WD_W'(0);
            end
            ST_RUN: begin
                hit_s = fail_in || (!test_done && wd_exp_s);
                if (hit_s) begin
                    fail_map_s = fail_map_r | cur_bit_s;
                    if (fail_code_r == 4'd0) begin
                        fail_code_s = code_r;
                    end else begin
                        fail_code_s = fail_code_r;
                    end
                end else begin
                    fail_map_s = fail_map_r;
                end
                if (test_done || wd_exp_s) begin
                    timeout_s  = timeout_r | ~test_done;
                    state_s    = ST_CLEAR;
                    select_s   = 4'd0;
                    rst_done_s = 1'b1;
                    clr_s      = CLR_W'(0);
                end else begin
                    wd_s = wd_r + WD_W'(1);
                end
            end
            ST_CLEAR: begin
                if (clr_r == CLR_LAST) begin
                    rst_done_s = 1'b0;
                    if ((STOP_ON_FAIL && ((fail_map_r & cur_bit_s) != 6'd0)) || (nxt_s == 4'd0)) begin
                        state_s = ST_FINISH;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (fail_map_r == 6'd0);
                    end else begin
                        state_s  = ST_ISSUE;
                        select_s = nxt_s;
                        code_s   = nxt_s;
                    end
                end else begin
                    clr_s = clr_r + CLR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces every output low immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            select_r    <= 4'd0;
            code_r      <= 4'd0;
            rst_done_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_map_r  <= 6'd0;
            fail_code_r <= 4'd0;
            timeout_r   <= 1'b0;
            wd_r        <= WD_W'(0);
            clr_r       <= CLR_W'(0);
        end else begin
            state_r     <= state_s;
            select_r    <= select_s;
            code_r      <= code_s;
            rst_done_r  <= rst_done_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            fail_map_r  <= fail_map_s;
            fail_code_r <= fail_code_s;
            timeout_r   <= timeout_s;
            wd_r        <= wd_s;
            clr_r       <= clr_s;
        end
    end

    assign select    = select_r;
    assign rst_done  = rst_done_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_map  = fail_map_r;
    assign fail_code = fail_code_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_mbist_sequencer.sv
// Scoreboard bench for mbist_sequencer: five parameter variants share stimulus;
// expected select order is queued at start and popped as each test is issued.
`timescale 1ns/1ps
module tb_mbist_sequencer;
    localparam int NDUT    = 5;
    localparam int DONE_AT = 10;
    localparam int BUDGET  = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       test_done;
    logic       fail_in;
    logic [3:0] sel_a   [NDUT];
    logic       rd_a    [NDUT];
    logic       busy_a  [NDUT];
    logic       done_a  [NDUT];
    logic       pass_a  [NDUT];
    logic [5:0] fmap_a  [NDUT];
    logic [3:0] fcode_a [NDUT];
    logic       to_a    [NDUT];

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    mbist_sequencer u_def (
        .clk(clk), .rst(rst), .start(start), .test_done(test_done), .fail_in(fail_in),
        .select(sel_a[0]), .rst_done(rd_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .fail_map(fmap_a[0]), .fail_code(fcode_a[0]), .timeout(to_a[0]));

    mbist_sequencer #(.STOP_ON_FAIL(1'b1)) u_sof (
        .clk(clk), .rst(rst), .start(start), .test_done(test_done), .fail_in(fail_in),
        .select(sel_a[1]), .rst_done(rd_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .fail_map(fmap_a[1]), .fail_code(fcode_a[1]), .timeout(to_a[1]));

    mbist_sequencer #(.TEST_MASK(6'b010010)) u_msk (
        .clk(clk), .rst(rst), .start(start), .test_done(test_done), .fail_in(fail_in),
        .select(sel_a[2]), .rst_done(rd_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .pass(pass_a[2]), .fail_map(fmap_a[2]), .fail_code(fcode_a[2]), .timeout(to_a[2]));

    mbist_sequencer #(.TEST_MASK(6'b000000)) u_zero (
        .clk(clk), .rst(rst), .start(start), .test_done(test_done), .fail_in(fail_in),
        .select(sel_a[3]), .rst_done(rd_a[3]), .busy(busy_a[3]), .done(done_a[3]),
        .pass(pass_a[3]), .fail_map(fmap_a[3]), .fail_code(fcode_a[3]), .timeout(to_a[3]));

    mbist_sequencer #(.TIMEOUT(16)) u_wd (
        .clk(clk), .rst(rst), .start(start), .test_done(test_done), .fail_in(fail_in),
        .select(sel_a[4]), .rst_done(rd_a[4]), .busy(busy_a[4]), .done(done_a[4]),
        .pass(pass_a[4]), .fail_map(fmap_a[4]), .fail_code(fcode_a[4]), .timeout(to_a[4]));

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays the algorithm engine for one sequence on DUT idx and scores what it issues.
    task automatic run_seq(input int idx, input logic [5:0] mask, input bit stop, input int tmo,
                           input logic [5:0] fmask, input int fail_at, input int wd_code,
                           input bit extra, input int abort_code);
        int cyc, k, exp_lat, rd_cnt, n_tests, exp_len;
        logic [3:0] sel, prev, exp_code;
        bit fin, failed;
        exp_lat = 1;
        n_tests = 0;
        for (int c = 1; c <= 6; c++) begin
            if (mask[c-1]) begin
                exp_q.push_back(4'(c));
                n_tests++;
                exp_lat += ((c == wd_code) ? tmo : DONE_AT) + 2;
                failed = fmask[c-1] || (c == wd_code);
                if (stop && failed) break;
            end
        end
        cyc = 0; k = 0; rd_cnt = 0; prev = 4'd0; fin = 1'b0;
        start = 1'b1;
        while (!fin && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; test_done = 1'b0; fail_in = 1'b0;
            sel = sel_a[idx];
            if (rd_a[idx] === 1'b1) rd_cnt++;
            if (cyc == 1 && mask != 6'd0) begin
                checks++;
                if (done_a[idx] !== 1'b0 || pass_a[idx] !== 1'b0 || fmap_a[idx] !== 6'd0 ||
                    fcode_a[idx] !== 4'd0 || to_a[idx] !== 1'b0)
                begin
                    errors++;
                    $display("FAIL start_clear: dut%0d done=%b pass=%b map=%b code=%0d to=%b, required all 0",
                             idx, done_a[idx], pass_a[idx], fmap_a[idx], fcode_a[idx], to_a[idx]);
                end
            end
            if (sel != 4'd0) begin
                if (prev == 4'd0) begin
                    k = 0;
                    exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
                    checks++;
                    if (sel !== exp_code || busy_a[idx] !== 1'b1) begin
                        errors++;
                        $display("FAIL select_order: dut%0d select=%0d busy=%b, required select=%0d busy=1",
                                 idx, sel, busy_a[idx], exp_code);
                    end
                end else begin
                    k++;
                    checks++;
                    if (sel !== prev) begin
                        errors++;
                        $display("FAIL select_jump: dut%0d select %0d -> %0d, required stable", idx, prev, sel);
                    end
                end
                if (int'(sel) != wd_code && k == DONE_AT) test_done = 1'b1;
                if (extra && k == 0) test_done = 1'b1;
                if (extra && k == 5) start = 1'b1;
                if (sel <= 4'd6 && fmask[int'(sel)-1] && k == fail_at) fail_in = 1'b1;
                if (int'(sel) == abort_code && k == 5) return;
            end else if (prev != 4'd0) begin
                exp_len = (int'(prev) == wd_code) ? tmo : DONE_AT;
                checks++;
                if (k != exp_len || rd_a[idx] !== 1'b1) begin
                    errors++;
                    $display("FAIL run_length: dut%0d code %0d ran %0d rst_done=%b, required %0d rst_done=1",
                             idx, prev, k, rd_a[idx], exp_len);
                end
                if (int'(prev) == wd_code) begin
                    checks++;
                    if (to_a[idx] !== 1'b1) begin
                        errors++;
                        $display("FAIL watchdog_edge: dut%0d timeout=%b on entering clear, required 1", idx, to_a[idx]);
                    end
                end
            end
            if (done_a[idx] === 1'b1) fin = 1'b1;
            prev = sel;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL seq_timeout: dut%0d no done within %0d cycles", idx, BUDGET);
        end else if (cyc != exp_lat || rd_cnt != n_tests || exp_q.size() != 0 || busy_a[idx] !== 1'b0 ||
                     sel_a[idx] !== 4'd0 || rd_a[idx] !== 1'b0) begin
            errors++;
            $display("FAIL seq_end: dut%0d latency=%0d clears=%0d left=%0d busy=%b sel=%0d rd=%b, required %0d %0d 0 0 0 0",
                     idx, cyc, rd_cnt, exp_q.size(), busy_a[idx], sel_a[idx], rd_a[idx], exp_lat, n_tests);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (sel_a[i] !== 4'd0 || rd_a[i] !== 1'b0 || busy_a[i] !== 1'b0 || done_a[i] !== 1'b0 ||
                pass_a[i] !== 1'b0 || fmap_a[i] !== 6'd0 || fcode_a[i] !== 4'd0 || to_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: dut%0d sel=%0d rd=%b busy=%b done=%b pass=%b map=%b code=%0d to=%b, required all 0",
                         i, sel_a[i], rd_a[i], busy_a[i], done_a[i], pass_a[i], fmap_a[i], fcode_a[i], to_a[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_full_pass();
        run_seq(0, 6'b111111, 1'b0, 1024, 6'd0, 5, 0, 1'b0, 0);
        checks++;
        if (done_a[0] !== 1'b1 || pass_a[0] !== 1'b1 || fmap_a[0] !== 6'd0 || fcode_a[0] !== 4'd0 || to_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_pass: done=%b pass=%b map=%b code=%0d to=%b, required 1 1 000000 0 0",
                     done_a[0], pass_a[0], fmap_a[0], fcode_a[0], to_a[0]);
        end
    endtask

    task automatic test_fail_codes();
        run_seq(0, 6'b111111, 1'b0, 1024, 6'b010100, 5, 0, 1'b0, 0);
        checks++;
        if (pass_a[0] !== 1'b0 || fmap_a[0] !== 6'b010100 || fcode_a[0] !== 4'd3 || to_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL fail_codes: pass=%b map=%b code=%0d to=%b, required 0 010100 3 0",
                     pass_a[0], fmap_a[0], fcode_a[0], to_a[0]);
        end
    endtask

    task automatic test_back_to_back();
        run_seq(0, 6'b111111, 1'b0, 1024, 6'd0, 5, 0, 1'b0, 0);
        checks++;
        if (pass_a[0] !== 1'b1 || fmap_a[0] !== 6'd0 || fcode_a[0] !== 4'd0) begin
            errors++;
            $display("FAIL back_to_back: pass=%b map=%b code=%0d, required 1 000000 0",
                     pass_a[0], fmap_a[0], fcode_a[0]);
        end
    endtask

    task automatic test_stop_on_fail();
        do_reset();
        run_seq(1, 6'b111111, 1'b1, 1024, 6'b010100, 5, 0, 1'b0, 0);
        checks++;
        if (pass_a[1] !== 1'b0 || fmap_a[1] !== 6'b000100 || fcode_a[1] !== 4'd3) begin
            errors++;
            $display("FAIL stop_on_fail: pass=%b map=%b code=%0d, required 0 000100 3",
                     pass_a[1], fmap_a[1], fcode_a[1]);
        end
    endtask

    task automatic test_mask();
        do_reset();
        run_seq(2, 6'b010010, 1'b0, 1024, 6'd0, 5, 0, 1'b0, 0);
        checks++;
        if (pass_a[2] !== 1'b1 || done_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL mask_subset: pass=%b done=%b, required 1 1", pass_a[2], done_a[2]);
        end
    endtask

    task automatic test_mask_zero();
        do_reset();
        run_seq(3, 6'b000000, 1'b0, 1024, 6'd0, 5, 0, 1'b0, 0);
        checks++;
        if (pass_a[3] !== 1'b1 || done_a[3] !== 1'b1 || fmap_a[3] !== 6'd0) begin
            errors++;
            $display("FAIL mask_zero: pass=%b done=%b map=%b, required 1 1 000000", pass_a[3], done_a[3], fmap_a[3]);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        run_seq(4, 6'b111111, 1'b0, 16, 6'd0, 5, 1, 1'b0, 0);
        checks++;
        if (to_a[4] !== 1'b1 || fmap_a[4] !== 6'b000001 || fcode_a[4] !== 4'd1 || pass_a[4] !== 1'b0) begin
            errors++;
            $display("FAIL watchdog: to=%b map=%b code=%0d pass=%b, required 1 000001 1 0",
                     to_a[4], fmap_a[4], fcode_a[4], pass_a[4]);
        end
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        run_seq(0, 6'b111111, 1'b0, 1024, 6'b000010, DONE_AT, 0, 1'b1, 0);
        checks++;
        if (fmap_a[0] !== 6'b000010 || fcode_a[0] !== 4'd2 || to_a[0] !== 1'b0 || pass_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignored_inputs: map=%b code=%0d to=%b pass=%b, required 000010 2 0 0",
                     fmap_a[0], fcode_a[0], to_a[0], pass_a[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        run_seq(0, 6'b111111, 1'b0, 1024, 6'b000010, 5, 0, 1'b0, 4);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sel_a[0] !== 4'd0 || rd_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 ||
            pass_a[0] !== 1'b0 || fmap_a[0] !== 6'd0 || fcode_a[0] !== 4'd0 || to_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: sel=%0d rd=%b busy=%b done=%b pass=%b map=%b code=%0d to=%b, required all 0",
                     sel_a[0], rd_a[0], busy_a[0], done_a[0], pass_a[0], fmap_a[0], fcode_a[0], to_a[0]);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0; test_done = 1'b0; fail_in = 1'b0;
        run_seq(0, 6'b111111, 1'b0, 1024, 6'd0, 5, 0, 1'b0, 0);
        checks++;
        if (pass_a[0] !== 1'b1 || fmap_a[0] !== 6'd0 || fcode_a[0] !== 4'd0) begin
            errors++;
            $display("FAIL restart_after_reset: pass=%b map=%b code=%0d, required 1 000000 0",
                     pass_a[0], fmap_a[0], fcode_a[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_done = 1'b0;
        fail_in = 1'b0;
        test_reset();
        test_full_pass();
        test_fail_codes();
        test_back_to_back();
        test_stop_on_fail();
        test_mask();
        test_mask_zero();
        test_watchdog();
        test_ignored_inputs();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
